// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID fetch queue with FIFO order, flush and decoded register fields; IF_ID_BYPASS_EN adds same-cycle empty-queue bypass
package if_id_queue_pkg;
   typedef logic [2:0] lc3b_reg;
endpackage

module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enq_valid,
   input  logic [15:0]                  enq_pc,
   input  logic [15:0]                  enq_instr,
   output logic                         enq_ready,
   input  logic                         flush,
   input  logic                         deq_ready,
   output logic                         deq_valid,
   output logic [15:0]                  deq_pc,
   output logic [15:0]                  deq_instr,
   output lc3b_reg                      deq_src1,
   output lc3b_reg                      deq_src2,
   output lc3b_reg                      deq_dest,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   pc_mem_q    [DEPTH];
   logic [15:0]   instr_mem_q [DEPTH];
   logic          empty, bypass, mem_enq, mem_deq;
   logic [15:0]   head_pc, head_instr;
   logic [3:0]    op;
   // Head selection: stored entry, or the incoming fetch when bypassing an empty queue
   always_comb begin
      empty = count_q == '0;
`ifdef IF_ID_BYPASS_EN
      bypass     = ~reset & empty & enq_valid & ~flush;
      head_pc    = bypass ? enq_pc : pc_mem_q[head_q];
      head_instr = bypass ? enq_instr : instr_mem_q[head_q];
`else
      bypass     = 1'b0;
      head_pc    = pc_mem_q[head_q];
      head_instr = instr_mem_q[head_q];
`endif
   end
   // Handshakes and next pointer/count state; a consumed bypass entry never touches storage
   always_comb begin
      enq_ready = count_q != CW'(DEPTH);
      deq_valid = ~flush & (~empty | bypass);
      mem_deq   = ~flush & ~empty & deq_ready;
      mem_enq   = ~flush & enq_valid & enq_ready & ~(bypass & deq_ready);
      head_d    = flush ? '0 : head_q + AW'(mem_deq);
      tail_d    = flush ? '0 : tail_q + AW'(mem_enq);
      count_d   = flush ? '0 : count_q + CW'(mem_enq) - CW'(mem_deq);
   end
   // Pointer and occupancy registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // Entry storage is left unreset; invalid heads are masked to zero at the outputs
   always_ff @(posedge clk) begin
      if (mem_enq) begin
         pc_mem_q[tail_q]    <= enq_pc;
         instr_mem_q[tail_q] <= enq_instr;
      end
   end
   // Masked head outputs and register-field decode; stores read their source from [11:9]
   always_comb begin
      deq_pc    = deq_valid ? head_pc : 16'h0000;
      deq_instr = deq_valid ? head_instr : 16'h0000;
      op        = deq_instr[15:12];
      deq_dest  = deq_instr[11:9];
      deq_src1  = deq_instr[8:6];
      deq_src2  = (op == 4'b0011 || op == 4'b0111 || op == 4'b1011) ? deq_instr[11:9] : deq_instr[2:0];
      count     = count_q;
   end
endmodule
